// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the byte-oriented SPI master.
//   spi_state_t    : FSM states of the master (IDLE, SETUP, XFER, HOLD)
//   MODE0..MODE3   : SPI mode constants encoded as {cpol, cpha}
//   edge_is_sample : tells whether a given sclk edge is the miso sampling edge
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // SPI modes, {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // cpha=0 samples on the leading edge, cpha=1 on the trailing edge.
    // The other edge of each pair is the one that drives mosi.
    function automatic logic edge_is_sample(input logic i_cpha, input logic i_leading);
        return i_leading ^ i_cpha;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Divider that paces the SPI master. While enabled it counts CLK_DIV clk cycles
// and raises a one-cycle strobe at the end of each period. A phase bit flips on
// every strobe so the master knows whether a strobe is a leading or a trailing
// sclk edge. Disabling the block clears both counter and phase, so the first
// strobe after enable is always a leading edge, CLK_DIV cycles later.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   i_en       in   count enable (master busy)
//   o_strobe   out  one-cycle pulse at the end of each CLK_DIV period
//   o_leading  out  1 when the current strobe is a leading edge
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_strobe,
    output logic o_leading
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_strobe  = i_en && (r_cnt == LAST_CNT);
    assign o_leading = ~r_phase;

endmodule

// File: rtl/master_spi.sv
// -----------------------------------------------------------------------------
// master_spi
// Byte-oriented SPI master, modes 0-3, MSB first, one transfer per start.
// A transfer is SETUP (CLK_DIV cycles, ss_n low), XFER (2*DATA_W sclk edges,
// one per CLK_DIV cycles, the first one at the end of SETUP) and HOLD
// (CLK_DIV cycles, ss_n already high). busy is high for
// CLK_DIV*(2*DATA_W+2) cycles.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, aborts any transfer
//   start     in   transfer request, only looked at while idle
//   cpol      in   sclk idle level, latched at start
//   cpha      in   sample edge select, latched at start
//   tx_data   in   word to send, latched at start
//   rx_data   out  last received word, updated with rx_valid
//   rx_valid  out  one-cycle pulse when rx_data is updated
//   busy      out  transfer in progress
//   ss_n      out  slave select, active low
//   sclk      out  SPI clock
//   mosi      out  master out
//   miso      in   master in (used without synchroniser)
// -----------------------------------------------------------------------------
module master_spi
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              ss_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int NUM_EDGES = 2 * DATA_W;
    localparam int EW        = $clog2(NUM_EDGES);
    localparam logic [EW-1:0] LAST_EDGE = EW'(NUM_EDGES - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("master_spi: CLK_DIV must be >= 2");
        end
        if (DATA_W < 2) begin : g_bad_data_w
            $error("master_spi: DATA_W must be >= 2");
        end
    endgenerate

    spi_state_t        r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_next;
    logic              r_rx_valid, w_rx_valid_next;
    logic              r_ss_n, w_ss_n_next;
    logic              r_sclk, w_sclk_next;
    logic              r_mosi, w_mosi_next;
    logic              r_cpol, w_cpol_next;
    logic              r_cpha, w_cpha_next;
    logic [EW-1:0]     r_edge_cnt, w_edge_cnt_next;

    logic w_clk_en;
    logic w_strobe;
    logic w_leading;
    logic w_do_edge;

    assign w_clk_en = (r_state != IDLE);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_clk_en),
        .o_strobe  (w_strobe),
        .o_leading (w_leading)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ss_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_ss_n     <= w_ss_n_next;
            r_sclk     <= w_sclk_next;
            r_mosi     <= w_mosi_next;
            r_cpol     <= w_cpol_next;
            r_cpha     <= w_cpha_next;
            r_edge_cnt <= w_edge_cnt_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_ss_n_next     = r_ss_n;
        w_sclk_next     = r_sclk;
        w_mosi_next     = r_mosi;
        w_cpol_next     = r_cpol;
        w_cpha_next     = r_cpha;
        w_edge_cnt_next = r_edge_cnt;
        w_do_edge       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next    = SETUP;
                    w_shift_next    = tx_data;
                    w_cpol_next     = cpol;
                    w_cpha_next     = cpha;
                    w_sclk_next     = cpol;
                    w_ss_n_next     = 1'b0;
                    w_edge_cnt_next = '0;
                    // cpha=0 needs the MSB on the wire before the first
                    // (sampling) edge; cpha=1 drives it on that edge instead.
                    if (!cpha) begin
                        w_mosi_next = tx_data[DATA_W-1];
                    end
                end
            end

            SETUP: begin
                // The strobe that ends SETUP is sclk edge 0.
                if (w_strobe) begin
                    w_state_next = XFER;
                    w_do_edge    = 1'b1;
                end
            end

            XFER: begin
                // r_edge_cnt is the index of the last edge issued; the strobe
                // after the final edge closes the last half-period.
                if (w_strobe) begin
                    if (r_edge_cnt == LAST_EDGE) begin
                        w_state_next    = HOLD;
                        w_ss_n_next     = 1'b1;
                        w_rx_valid_next = 1'b1;
                        w_rx_data_next  = r_shift;
                    end else begin
                        w_edge_cnt_next = r_edge_cnt + EW'(1);
                        w_do_edge       = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (w_strobe) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_ss_n_next  = 1'b1;
                w_sclk_next  = r_cpol;
            end
        endcase

        // One sclk edge: sampling edges shift miso into the LSB, the other
        // edges put the current MSB of the shift register onto mosi.
        if (w_do_edge) begin
            w_sclk_next = ~r_sclk;
            if (edge_is_sample(r_cpha, w_leading)) begin
                w_shift_next = {r_shift[DATA_W-2:0], miso};
            end else begin
                w_mosi_next = r_shift[DATA_W-1];
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != IDLE);
    assign ss_n     = r_ss_n;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;

endmodule
